// File: rtl/conv_channel_scheduler_pkg.sv
// Shared definitions for the Conv2d channel scheduler and its helpers:
// state encoding, default layer geometry and a small width helper.
package conv_channel_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_t;

    localparam int DEF_N        = 24;
    localparam int DEF_C        = 128;
    localparam int DEF_OUTCH    = 256;
    localparam int DEF_CONV_LAT = 4;

    // Width of an index able to address 'depth' items; never narrower than 1 bit
    // so that degenerate single-item configurations still elaborate.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_settle_timer.sv
// Settle timer: counts cycles after a load and flags the cycle in which the
// programmed latency has elapsed. Shared by the conv, pool and FC sequencers.
module conv_settle_timer
    import conv_channel_scheduler_pkg::*;
#(
    parameter  int LAT   = DEF_CONV_LAT,
    localparam int CNT_W = idx_width(LAT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic count,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Counter restarts from zero on load or clear and stops once it has expired,
    // so a caller that lingers in its wait state sees a steady expired flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || load) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(LAT - 1));

endmodule

// File: rtl/conv_channel_scheduler.sv
// Conv2d channel scheduler: walks one Conv2d instance through every output
// channel of a layer, fetching each filter, letting the result settle and
// handing the captured result map to the writer over valid/ready.
module conv_channel_scheduler
    import conv_channel_scheduler_pkg::*;
#(
    parameter  int N        = DEF_N,
    parameter  int C        = DEF_C,
    parameter  int OUTCH    = DEF_OUTCH,
    parameter  int CONV_LAT = DEF_CONV_LAT,
    parameter  int RES_W    = N * 8 * 40,
    localparam int CW       = idx_width(OUTCH),
    localparam int WW       = 9 * N * C
) (
    input  logic             clk,
    input  logic             global_rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             prm_req,
    output logic [CW-1:0]    prm_addr,
    input  logic             prm_valid,
    input  logic [WW-1:0]    prm_weight,
    input  logic [N-1:0]     prm_bias,
    output logic [WW-1:0]    filt_weight,
    output logic [N-1:0]     filt_bias,
    input  logic [RES_W-1:0] conv_result,
    output logic [RES_W-1:0] res_data,
    output logic [CW-1:0]    res_ch,
    output logic             res_valid,
    input  logic             res_ready
);

    sched_state_t  state;
    sched_state_t  next_state;
    logic [CW-1:0] ch;
    logic          last_ch;
    logic          start_layer;
    logic          latch_filt;
    logic          timer_load;
    logic          timer_count;
    logic          timer_expired;
    logic          capture_res;
    logic          advance_ch;

    assign last_ch = (ch == CW'(OUTCH - 1));

    conv_settle_timer #(
        .LAT (CONV_LAT)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (global_rst_n),
        .clear   (abort),
        .load    (timer_load),
        .count   (timer_count),
        .expired (timer_expired)
    );

    // Next-state and datapath strobes; abort overrides everything so that no
    // register update can sneak through in the cycle the layer is cancelled.
    always_comb begin
        next_state  = state;
        start_layer = 1'b0;
        latch_filt  = 1'b0;
        timer_load  = 1'b0;
        timer_count = 1'b0;
        capture_res = 1'b0;
        advance_ch  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state  = ST_FETCH;
                    start_layer = 1'b1;
                end
            end
            ST_FETCH: begin
                if (prm_valid) begin
                    next_state = ST_SETTLE;
                    latch_filt = 1'b1;
                    timer_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                timer_count = 1'b1;
                if (timer_expired) begin
                    next_state  = ST_EMIT;
                    capture_res = 1'b1;
                end
            end
            ST_EMIT: begin
                if (res_ready) begin
                    if (last_ch) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_FETCH;
                        advance_ch = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (abort) begin
            next_state  = ST_IDLE;
            start_layer = 1'b0;
            latch_filt  = 1'b0;
            timer_load  = 1'b0;
            capture_res = 1'b0;
            advance_ch  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Output-channel counter; terminal at OUTCH-1, cleared by a new layer or abort.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            ch <= '0;
        end else if (abort || start_layer) begin
            ch <= '0;
        end else if (advance_ch) begin
            ch <= ch + CW'(1);
        end
    end

    // Filter holding registers; only a fetch completion may change what Conv2d sees.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            filt_weight <= '0;
            filt_bias   <= '0;
        end else if (latch_filt) begin
            filt_weight <= prm_weight;
            filt_bias   <= prm_bias;
        end
    end

    // Result holding registers; frozen for the whole EMIT handshake.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            res_data <= '0;
            res_ch   <= '0;
        end else if (capture_res) begin
            res_data <= conv_result;
            res_ch   <= ch;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign prm_req   = (state == ST_FETCH);
    assign prm_addr  = ch;
    assign res_valid = (state == ST_EMIT);

endmodule

// File: tb/tb_conv_channel_scheduler.sv
// Directed bench for conv_channel_scheduler: small layer (4 channels,
// settle latency 3), parameter memory and Conv2d modelled in the bench.
module tb_conv_channel_scheduler;

    localparam int TN   = 8;
    localparam int TC   = 1;
    localparam int TOUT = 4;
    localparam int TLAT = 3;
    localparam int TRES = 32;
    localparam int WW   = 9 * TN * TC;
    localparam int CW   = 2;

    logic            clk;
    logic            global_rst_n;
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            prm_req;
    logic [CW-1:0]   prm_addr;
    logic            prm_valid;
    logic [WW-1:0]   prm_weight;
    logic [TN-1:0]   prm_bias;
    logic [WW-1:0]   filt_weight;
    logic [TN-1:0]   filt_bias;
    logic [TRES-1:0] conv_result;
    logic [TRES-1:0] res_data;
    logic [CW-1:0]   res_ch;
    logic            res_valid;
    logic            res_ready;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [TRES-1:0] conv_pipe [0:TLAT-2];

    conv_channel_scheduler #(
        .N        (TN),
        .C        (TC),
        .OUTCH    (TOUT),
        .CONV_LAT (TLAT),
        .RES_W    (TRES)
    ) dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .prm_req      (prm_req),
        .prm_addr     (prm_addr),
        .prm_valid    (prm_valid),
        .prm_weight   (prm_weight),
        .prm_bias     (prm_bias),
        .filt_weight  (filt_weight),
        .filt_bias    (filt_bias),
        .conv_result  (conv_result),
        .res_data     (res_data),
        .res_ch       (res_ch),
        .res_valid    (res_valid),
        .res_ready    (res_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conv2d stand-in: a new filter needs TLAT-1 edges to reach conv_result,
    // so a capture one cycle early would see the previous channel's map.
    function automatic logic [TRES-1:0] conv_fn(input logic [WW-1:0] w, input logic [TN-1:0] b);
        logic [7:0] wl;
        wl = w[7:0];
        return {8'hA5, wl, b, wl + b};
    endfunction

    always @(posedge clk) begin
        conv_pipe[0] <= conv_fn(filt_weight, filt_bias);
        for (int i = 1; i < TLAT - 1; i++) conv_pipe[i] <= conv_pipe[i-1];
    end
    assign conv_result = conv_pipe[TLAT-2];

    // Done pulses are tallied on the edge that consumes them.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // Expected result map for channel ch: memory returns weight=ch*0x11, bias=ch+1.
    function automatic logic [TRES-1:0] exp_conv(input int ch);
        logic [7:0] w;
        logic [7:0] b;
        w = 8'(ch * 17);
        b = 8'(ch + 1);
        return {8'hA5, w, b, w + b};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drop_valid();
        prm_valid  = 1'b0;
        prm_weight = {9{8'hEE}};
        prm_bias   = 8'hEE;
    endtask

    task automatic wait_req(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (prm_req === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    // Waits `delay` cycles, then presents channel ch's parameters with prm_valid.
    task automatic serve_fetch(input int ch, input int delay);
        for (int i = 0; i < delay; i++) tick();
        prm_weight = WW'(ch * 17);
        prm_bias   = 8'(ch + 1);
        prm_valid  = 1'b1;
    endtask

    // Counts cycles from the prm_valid cycle until res_valid is seen.
    task automatic wait_res(output int lat, output bit timed_out);
        lat = 0;
        timed_out = 1'b1;
        while (lat < 50) begin
            tick();
            lat++;
            if (lat == 1) drop_valid();
            if (res_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic pulse_ready();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // Reset values, both while reset is held and right after release.
    task automatic test_reset();
        global_rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        res_ready = 1'b0;
        drop_valid();
        tick();
        tick();
        checks++;
        if ({busy, done, prm_req, res_valid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: busy/done/req/valid=%b want 0000", {busy, done, prm_req, res_valid});
        end
        checks++;
        if (filt_weight !== '0 || filt_bias !== '0 || res_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: filt_w=%h filt_b=%h res=%h want 0", filt_weight, filt_bias, res_data);
        end
        checks++;
        if (prm_addr !== '0 || res_ch !== '0) begin
            errors++;
            $display("[TB] FAIL reset_idx: prm_addr=%0d res_ch=%0d want 0", prm_addr, res_ch);
        end
        global_rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    // Full layer with the writer always ready.
    task automatic test_full_layer();
        bit to;
        int lat;
        done_cnt = 0;
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (prm_req !== 1'b1 || prm_addr !== '0) begin
            errors++;
            $display("[TB] FAIL t1_start_req: req=%b addr=%0d want 1/0", prm_req, prm_addr);
        end
        for (int ch = 0; ch < TOUT; ch++) begin
            wait_req(to);
            checks++;
            if (to || prm_addr !== CW'(ch)) begin
                errors++;
                $display("[TB] FAIL t1_addr ch%0d: timeout=%0d addr=%0d want %0d", ch, to, prm_addr, ch);
            end
            serve_fetch(ch, 2);
            wait_res(lat, to);
            checks++;
            if (to || lat != TLAT + 1) begin
                errors++;
                $display("[TB] FAIL t1_latency ch%0d: got %0d cycles want %0d", ch, lat, TLAT + 1);
            end
            checks++;
            if (res_ch !== CW'(ch)) begin
                errors++;
                $display("[TB] FAIL t1_res_ch: got %0d want %0d", res_ch, ch);
            end
            checks++;
            if (res_data !== exp_conv(ch)) begin
                errors++;
                $display("[TB] FAIL t1_res_data ch%0d: got %h want %h", ch, res_data, exp_conv(ch));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL t1_done: done=%b busy=%b want 1/1", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL t1_end: done=%b busy=%b pulses=%0d want 0/0/1", done, busy, done_cnt);
        end
        res_ready = 1'b0;
    endtask

    // Writer stalls for 10 cycles on channel 1.
    task automatic test_stall();
        bit to;
        int lat;
        int bad;
        logic [TRES-1:0] held;
        res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_req(to);
        serve_fetch(0, 1);
        wait_res(lat, to);
        pulse_ready();
        wait_req(to);
        serve_fetch(1, 1);
        wait_res(lat, to);
        held = res_data;
        checks++;
        if (to || held !== exp_conv(1) || res_ch !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL t2_ch1_result: data=%h ch=%0d want %h/1", held, res_ch, exp_conv(1));
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== held || res_ch !== CW'(1) || prm_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL t2_stall_hold: %0d unstable cycles want 0", bad);
        end
        pulse_ready();
        checks++;
        if (prm_req !== 1'b1 || prm_addr !== CW'(2) || res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t2_resume: req=%b addr=%0d valid=%b want 1/2/0", prm_req, prm_addr, res_valid);
        end
        res_ready = 1'b1;
        tick();
        tick();
        res_ready = 1'b0;
        checks++;
        if (prm_req !== 1'b1 || prm_addr !== CW'(2)) begin
            errors++;
            $display("[TB] FAIL t2_ready_no_valid: req=%b addr=%0d want 1/2", prm_req, prm_addr);
        end
        for (int ch = 2; ch < TOUT; ch++) begin
            wait_req(to);
            serve_fetch(ch, 0);
            wait_res(lat, to);
            pulse_ready();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL t2_done: got %b want 1", done);
        end
        tick();
    endtask

    // Stray prm_valid in IDLE and in SETTLE must be ignored.
    task automatic test_stray_valid();
        bit to;
        int lat;
        prm_valid = 1'b1;
        tick();
        drop_valid();
        checks++;
        if (busy !== 1'b0 || filt_weight !== WW'(3 * 17) || filt_bias !== 8'd4) begin
            errors++;
            $display("[TB] FAIL t3_idle_valid: busy=%b filt_w=%h filt_b=%h want 0/33/4", busy, filt_weight, filt_bias);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_req(to);
        serve_fetch(0, 0);
        tick();
        prm_valid = 1'b1;
        tick();
        drop_valid();
        checks++;
        if (filt_weight !== '0 || filt_bias !== 8'd1 || prm_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t3_settle_valid: filt_w=%h filt_b=%h req=%b want 0/1/0", filt_weight, filt_bias, prm_req);
        end
        lat = 2;
        while (res_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != TLAT + 1 || res_data !== exp_conv(0)) begin
            errors++;
            $display("[TB] FAIL t3_result: lat=%0d data=%h want %0d/%h", lat, res_data, TLAT + 1, exp_conv(0));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t3_abort_emit: busy=%b valid=%b want 0/0", busy, res_valid);
        end
    endtask

    // Abort during SETTLE of channel 2, then restart.
    task automatic test_abort();
        bit to;
        int lat;
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            wait_req(to);
            serve_fetch(ch, 1);
            wait_res(lat, to);
            pulse_ready();
        end
        wait_req(to);
        serve_fetch(2, 1);
        tick();
        drop_valid();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || prm_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t4_abort: busy=%b valid=%b req=%b want 0/0/0", busy, res_valid, prm_req);
        end
        checks++;
        if (filt_weight !== WW'(2 * 17) || filt_bias !== 8'd3) begin
            errors++;
            $display("[TB] FAIL t4_filt_kept: filt_w=%h filt_b=%h want 22/3", filt_weight, filt_bias);
        end
        tick();
        tick();
        tick();
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t4_no_done: pulses=%0d busy=%b want 0/0", done_cnt, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (prm_req !== 1'b1 || prm_addr !== '0) begin
            errors++;
            $display("[TB] FAIL t4_restart: req=%b addr=%0d want 1/0", prm_req, prm_addr);
        end
    endtask

    // Asynchronous reset while channel 1 is waiting in EMIT.
    task automatic test_async_reset();
        bit to;
        int lat;
        wait_req(to);
        serve_fetch(0, 0);
        wait_res(lat, to);
        pulse_ready();
        wait_req(to);
        serve_fetch(1, 0);
        wait_res(lat, to);
        checks++;
        if (to || res_ch !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL t5_pre_emit: timeout=%0d res_ch=%0d want 0/1", to, res_ch);
        end
        #2;
        global_rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, prm_req, res_valid} !== 4'b0000 || prm_addr !== '0 || res_ch !== '0) begin
            errors++;
            $display("[TB] FAIL t5_async_ctrl: b/d/r/v=%b addr=%0d ch=%0d want 0", {busy, done, prm_req, res_valid}, prm_addr, res_ch);
        end
        checks++;
        if (res_data !== '0 || filt_weight !== '0 || filt_bias !== '0) begin
            errors++;
            $display("[TB] FAIL t5_async_data: res=%h filt_w=%h filt_b=%h want 0", res_data, filt_weight, filt_bias);
        end
        tick();
        prm_weight = WW'(8'h77);
        prm_bias = 8'h77;
        prm_valid = 1'b1;
        global_rst_n = 1'b1;
        tick();
        drop_valid();
        checks++;
        if (busy !== 1'b0 || filt_weight !== '0) begin
            errors++;
            $display("[TB] FAIL t5_late_valid: busy=%b filt_w=%h want 0/0", busy, filt_weight);
        end
    endtask

    // start while busy and start+abort in IDLE are ignored.
    task automatic test_start_ignored();
        bit to;
        int lat;
        int timeouts;
        logic [7:0] seq;
        done_cnt = 0;
        timeouts = 0;
        seq = '0;
        res_ready = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || prm_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t6_start_abort: busy=%b req=%b want 0/0", busy, prm_req);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int ch = 0; ch < TOUT; ch++) begin
            wait_req(to);
            if (to) timeouts++;
            if (ch == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            serve_fetch(ch, 1);
            if (ch == 0) begin
                tick();
                start = 1'b1;
                tick();
                start = 1'b0;
                while (res_valid !== 1'b1 && lat < 50) begin
                    tick();
                    lat++;
                end
            end else begin
                wait_res(lat, to);
                if (to) timeouts++;
            end
            drop_valid();
            seq = {seq[5:0], res_ch};
            tick();
        end
        checks++;
        if (seq !== 8'h1B || timeouts != 0) begin
            errors++;
            $display("[TB] FAIL t6_order: res_ch seq=%h timeouts=%0d want 1b/0", seq, timeouts);
        end
        tick();
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t6_done: pulses=%0d busy=%b want 1/0", done_cnt, busy);
        end
        res_ready = 1'b0;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_full_layer();
        test_stall();
        test_stray_valid();
        test_abort();
        test_async_reset();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
